// File: rtl/layeriomem_wrpacker_pkg.sv
// Shared types and constants for the layer-IO memory write packer.
// Geometry parameters, instruction / dfifo word layouts, FSM encodings.
package layeriomem_wrpacker_pkg;

    localparam int CLKDIV  = 4;
    localparam int DATA_W  = 64;
    localparam int DIGIT_W = 16;
    localparam int ADDR_W  = 14;
    localparam int DFIFO_W = DATA_W + DIGIT_W + ADDR_W;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    localparam digit_t CLKDIV_D = digit_t'(CLKDIV);

    // Field order matches instruc_d = {offset, stride_h, size_h, size_w}.
    typedef struct packed {
        digit_t offset;
        digit_t stride_h;
        digit_t size_h;
        digit_t size_w;
    } wr_instruc_t;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        digit_t            addressmem_address;
        addr_t             addressmem_d;
    } wr_dfifo_d_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic digit_t lane_popcount(input logic [CLKDIV-1:0] v);
        digit_t n;
        n = '0;
        for (int i = 0; i < CLKDIV; i++) begin
            n = n + digit_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/layeriomem_wrpacker_if.sv
// Bus bundle of the write packer: instruction FIFO, input beat stream,
// per-lane dfifo push side and layer status. slave = packer, master = env.
interface layeriomem_wrpacker_if;
    import layeriomem_wrpacker_pkg::*;

    logic                      instruc_valid;
    logic [4*DIGIT_W-1:0]      instruc_d;
    logic                      instruc_rdreq;
    logic                      in_valid;
    logic [CLKDIV*DATA_W-1:0]  in_value;
    logic                      in_ready;
    logic [CLKDIV-1:0]         dfifo_full;
    logic [CLKDIV-1:0]         dfifo_wrreq;
    logic [CLKDIV*DFIFO_W-1:0] dfifo_d;
    logic                      wrote_layer;
    digit_t                    total_writes;

    modport slave (
        input  instruc_valid, instruc_d, in_valid, in_value, dfifo_full,
        output instruc_rdreq, in_ready, dfifo_wrreq, dfifo_d,
        output wrote_layer, total_writes
    );

    modport master (
        output instruc_valid, instruc_d, in_valid, in_value, dfifo_full,
        input  instruc_rdreq, in_ready, dfifo_wrreq, dfifo_d,
        input  wrote_layer, total_writes
    );

endinterface

// File: rtl/layeriomem_wr_addrgen.sv
// Per-beat address generator: w/h counters, row accumulators, lane masks.
// Ports: clk, resetn, load (capture instr), accept (advance), lane outputs, last_beat.
module layeriomem_wr_addrgen
    import layeriomem_wrpacker_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load,
    input  logic                     accept,
    input  wr_instruc_t              instr,
    output logic [CLKDIV-1:0]        lane_en,
    output digit_t [CLKDIV-1:0]      lane_idx,
    output addr_t [CLKDIV-1:0]       lane_addr,
    output logic                     last_beat
);

    digit_t size_w_q, size_w_d;
    digit_t size_h_q, size_h_d;
    digit_t stride_q, stride_d;
    digit_t w_q, w_d;
    digit_t h_q, h_d;
    digit_t row_idx_q, row_idx_d;
    digit_t row_base_q, row_base_d;
    logic   row_end;

    // One extra bit so w+CLKDIV never wraps near the top of the range.
    assign row_end   = ({1'b0, w_q} + {1'b0, CLKDIV_D}) >= {1'b0, size_w_q};
    assign last_beat = row_end && (h_q == size_h_q - digit_t'(1));

    always_comb begin
        size_w_d   = size_w_q;
        size_h_d   = size_h_q;
        stride_d   = stride_q;
        w_d        = w_q;
        h_d        = h_q;
        row_idx_d  = row_idx_q;
        row_base_d = row_base_q;
        if (load) begin
            size_w_d   = instr.size_w;
            size_h_d   = instr.size_h;
            stride_d   = instr.stride_h;
            w_d        = '0;
            h_d        = '0;
            row_idx_d  = '0;
            row_base_d = instr.offset;
        end else if (accept) begin
            if (row_end) begin
                w_d        = '0;
                h_d        = h_q + digit_t'(1);
                row_idx_d  = row_idx_q + size_w_q;
                row_base_d = row_base_q + stride_q;
            end else begin
                w_d = w_q + CLKDIV_D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            size_w_q   <= '0;
            size_h_q   <= '0;
            stride_q   <= '0;
            w_q        <= '0;
            h_q        <= '0;
            row_idx_q  <= '0;
            row_base_q <= '0;
        end else begin
            size_w_q   <= size_w_d;
            size_h_q   <= size_h_d;
            stride_q   <= stride_d;
            w_q        <= w_d;
            h_q        <= h_d;
            row_idx_q  <= row_idx_d;
            row_base_q <= row_base_d;
        end
    end

    for (genvar i = 0; i < CLKDIV; i++) begin : g_lane
        localparam logic [DIGIT_W:0] OFF_X = (DIGIT_W + 1)'(i);
        localparam digit_t           OFF   = digit_t'(i);
        digit_t addr_full;

        assign lane_en[i]  = ({1'b0, w_q} + OFF_X) < {1'b0, size_w_q};
        assign lane_idx[i] = row_idx_q + w_q + OFF;
        assign addr_full   = row_base_q + w_q + OFF;
        // Physical address wraps modulo 2^ADDR_W.
        assign lane_addr[i] = addr_full[ADDR_W-1:0];
    end

endmodule

// File: rtl/layeriomem_wrpacker.sv
// Write-side producer for the layer-IO memory: FSM, handshake, dfifo regs.
// Ports: clk, resetn (sync, active-low), bus (layeriomem_wrpacker_if.slave).
// Option LAYERIOMEM_WRPACKER_COUNT_EN: total_writes counter + count check.
module layeriomem_wrpacker
    import layeriomem_wrpacker_pkg::*;
(
    input logic                  clk,
    input logic                  resetn,
    layeriomem_wrpacker_if.slave bus
);

    logic [1:0]               state_q, state_d;
    wr_instruc_t              instr_in;
    logic                     load;
    logic                     in_ready;
    logic                     accept;
    logic                     last_beat;
    logic                     size_zero;
    logic [CLKDIV-1:0]        lane_en;
    digit_t [CLKDIV-1:0]      lane_idx;
    addr_t [CLKDIV-1:0]       lane_addr;
    logic [CLKDIV-1:0]        wrreq_q, wrreq_d;
    wr_dfifo_d_t [CLKDIV-1:0] dout_q, dout_d;

    assign instr_in  = wr_instruc_t'(bus.instruc_d);
    assign load      = (state_q == ST_LOAD);
    assign size_zero = (instr_in.size_w == '0) || (instr_in.size_h == '0);
    // A beat is only taken when every lane has room, keeping lanes in lockstep.
    assign in_ready  = (state_q == ST_RUN) && !(|bus.dfifo_full);
    assign accept    = bus.in_valid && in_ready;

    layeriomem_wr_addrgen u_addrgen (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .accept    (accept),
        .instr     (instr_in),
        .lane_en   (lane_en),
        .lane_idx  (lane_idx),
        .lane_addr (lane_addr),
        .last_beat (last_beat)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.instruc_valid) state_d = ST_LOAD;
            ST_LOAD: state_d = size_zero ? ST_DONE : ST_RUN;
            ST_RUN:  if (accept && last_beat) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wrreq_d = accept ? lane_en : '0;
        dout_d  = dout_q;
        if (accept) begin
            for (int i = 0; i < CLKDIV; i++) begin
                dout_d[i].value              = bus.in_value[i*DATA_W +: DATA_W];
                dout_d[i].addressmem_address = lane_idx[i];
                dout_d[i].addressmem_d       = lane_addr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            wrreq_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            wrreq_q <= wrreq_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.instruc_rdreq = load;
    assign bus.in_ready      = in_ready;
    assign bus.dfifo_wrreq   = wrreq_q;
    assign bus.dfifo_d       = dout_q;
    assign bus.wrote_layer   = (state_q == ST_DONE);

`ifdef LAYERIOMEM_WRPACKER_COUNT_EN
    digit_t total_q, total_d;
    digit_t expect_q, expect_d;
    logic   err_q, err_d;

    // The final beat's pushes are visible in DONE, so compare the next count.
    always_comb begin
        total_d  = total_q;
        expect_d = expect_q;
        err_d    = err_q;
        if (load) begin
            total_d  = '0;
            expect_d = instr_in.size_w * instr_in.size_h;
        end else begin
            total_d = total_q + lane_popcount(wrreq_q);
        end
        if ((state_q == ST_DONE) && (total_d != expect_q)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            total_q  <= '0;
            expect_q <= '0;
            err_q    <= 1'b0;
        end else begin
            total_q  <= total_d;
            expect_q <= expect_d;
            err_q    <= err_d;
        end
    end

    assign bus.total_writes = total_q;

    a_count_ok: assert property (@(posedge clk) disable iff (!resetn) !err_q);
`else
    assign bus.total_writes = '0;
`endif

endmodule

// File: tb/tb_layeriomem_wrpacker.sv
// Self-checking bench for layeriomem_wrpacker.
// Table vectors, corner sequences and random layers vs a loop-nest model.
module tb_layeriomem_wrpacker;
    import layeriomem_wrpacker_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    layeriomem_wrpacker_if bus();

    layeriomem_wrpacker dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int sw, sh, st, off;
        int stall;
        int abort_at;
        int exp_wr;
        int exp_last;
    } vec_t;

    typedef struct {
        logic [CLKDIV-1:0] mask;
        int idx[CLKDIV];
        int addr[CLKDIV];
    } beat_t;

    beat_t exp_q[$];
    logic [CLKDIV*DATA_W-1:0] vals[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wrreq"}, bus.dfifo_wrreq, 0);
        chk({tag, "_dfifo_d_nz"}, (bus.dfifo_d != '0), 0);
        chk({tag, "_wrote_layer"}, bus.wrote_layer, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_rdreq"}, bus.instruc_rdreq, 0);
        chk({tag, "_total"}, bus.total_writes, 0);
    endtask

    task automatic run_layer(input vec_t v, input bit bp, input int vprob);
        beat_t b;
        logic [CLKDIV*DATA_W-1:0] val;
        logic [DFIFO_W-1:0] lane;
        logic [CLKDIV-1:0] full;
        logic iv, er, pending, done;
        int k, pb, nb, stall_cnt, n_wr, last_addr, wait_c;

        exp_q.delete();
        vals.delete();
        for (int h = 0; h < v.sh; h++) begin
            for (int w = 0; w < v.sw; w += CLKDIV) begin
                for (int i = 0; i < CLKDIV; i++) begin
                    b.mask[i] = (w + i < v.sw);
                    b.idx[i]  = h * v.sw + w + i;
                    b.addr[i] = (v.off + h * v.st + w + i) % (1 << ADDR_W);
                end
                exp_q.push_back(b);
                for (int j = 0; j < CLKDIV * DATA_W / 32; j++)
                    val[j*32 +: 32] = $urandom;
                vals.push_back(val);
            end
        end
        nb = exp_q.size();

        bus.instruc_d = {DIGIT_W'(v.off), DIGIT_W'(v.st),
                         DIGIT_W'(v.sh), DIGIT_W'(v.sw)};
        bus.instruc_valid = 1'b1;
        wait_c = 0;
        while (bus.instruc_rdreq !== 1'b1 && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        chk("rdreq_seen", bus.instruc_rdreq, 1);
        bus.instruc_valid = 1'b0;

        // LOAD cycle: stray valid must be ignored.
        bus.in_valid = ($urandom_range(0, 99) < vprob);
        bus.dfifo_full = '0;
        #1;
        chk("in_ready_load", bus.in_ready, 0);
        pending = 0; done = 0; k = 0; pb = 0;
        stall_cnt = 0; n_wr = 0; last_addr = -1;

        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk);
            n_wr += $countones(bus.dfifo_wrreq);
            if (pending) begin
                chk("wrreq_mask", bus.dfifo_wrreq, exp_q[pb].mask);
                for (int i = 0; i < CLKDIV; i++) begin
                    if (exp_q[pb].mask[i]) begin
                        lane = bus.dfifo_d[i*DFIFO_W +: DFIFO_W];
                        chk("lane_value", lane[DFIFO_W-1 -: DATA_W],
                            vals[pb][i*DATA_W +: DATA_W]);
                        chk("lane_idx", lane[ADDR_W +: DIGIT_W], exp_q[pb].idx[i]);
                        chk("lane_addr", lane[ADDR_W-1:0], exp_q[pb].addr[i]);
                        last_addr = int'(lane[ADDR_W-1:0]);
                    end
                end
            end else begin
                chk("no_wrreq", bus.dfifo_wrreq, 0);
            end
            chk("rdreq_one_cycle", bus.instruc_rdreq, 0);
            if (bus.wrote_layer) begin
                chk("wrote_layer_after_last", k, nb);
                if (nb == 0) chk("wrote_layer_delay", cyc, 1);
                done = 1;
                break;
            end
            if (v.abort_at > 0 && k == v.abort_at) begin
                bus.in_valid = 1'b0;
                resetn = 1'b0;
                @(negedge clk);
                check_zero("abort");
                resetn = 1'b1;
                return;
            end
            if (v.stall >= 0 && k == v.stall && stall_cnt < 5) begin
                full = 4'b0100;
                iv = 1'b1;
                stall_cnt++;
            end else begin
                full = (bp && $urandom_range(0, 7) == 0) ?
                       CLKDIV'($urandom_range(1, 15)) : '0;
                iv = ($urandom_range(0, 99) < vprob);
            end
            bus.dfifo_full = full;
            bus.in_valid = iv;
            bus.in_value = (k < nb) ? vals[k] : '1;
            #1;
            er = (k < nb) && (full == '0);
            chk("in_ready", bus.in_ready, er);
            pending = iv && er;
            pb = k;
            if (pending) k++;
        end
        chk("layer_done", done, 1);
        chk("write_count", n_wr, v.exp_wr);
        if (v.exp_last >= 0) chk("last_addr", last_addr, v.exp_last);
        bus.in_valid = 1'b0;
        bus.dfifo_full = '0;
        @(negedge clk);
        chk("idle_wrreq", bus.dfifo_wrreq, 0);
        chk("wrote_layer_single", bus.wrote_layer, 0);
`ifdef LAYERIOMEM_WRPACKER_COUNT_EN
        chk("total_writes", bus.total_writes, v.sw * v.sh);
`else
        chk("total_writes", bus.total_writes, 0);
`endif
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;

        tbl[0] = '{8, 2, 16, 100, -1, 0, 16, 123};
        tbl[1] = '{6, 1, 0, 200, -1, 0, 6, 205};
        tbl[2] = '{8, 2, 16, 100, 1, 0, 16, 123};
        tbl[3] = '{4, 1, 0, 16382, -1, 0, 4, 1};
        tbl[4] = '{4, 0, 5, 9, -1, 0, 0, -1};
        tbl[5] = '{0, 3, 5, 9, -1, 0, 0, -1};
        tbl[6] = '{1, 1, 0, 7, -1, 0, 1, 7};
        tbl[7] = '{9, 3, 20, 50, -1, 0, 27, 98};
        tbl[8] = '{16, 1, 0, 0, -1, 2, 0, -1};
        tbl[9] = '{5, 2, 3, 0, -1, 0, 10, 7};

        bus.instruc_valid = 1'b0;
        bus.instruc_d = '0;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.dfifo_full = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_layer(tbl[i], 1'b0, 100);

        for (int r = 0; r < 25; r++) begin
            v.sw = $urandom_range(0, 13);
            v.sh = $urandom_range(0, 4);
            v.st = $urandom_range(0, 65535);
            v.off = $urandom_range(0, 65535);
            v.stall = -1;
            v.abort_at = 0;
            v.exp_wr = v.sw * v.sh;
            v.exp_last = -1;
            run_layer(v, 1'b1, 70);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
